sample_sequencer: RTL and testbench
===================================

Name: sample_sequencer

Overview:
Sequences playback of stored signal samples from a synchronous sample memory into the network block. On start it walks the memory from address 0 and presents each DATA_WIDTH-bit sample on a valid/ready stream. After each accepted sample it holds that sample for a fixed number of cycles. It drives bit 0 of the current sample as the serial line to the network. It supports one-shot and loop playback, abort, and a completion pulse.

Parameters:
DATA_WIDTH, 8, width of one sample.
MEM_DEPTH, 100, number of sample memory entries.
ADDR_WIDTH, 7, memory address width; must satisfy 2^ADDR_WIDTH >= MEM_DEPTH.
HOLD_CYCLES, 10, cycles each accepted sample is held, counted from the handshake cycle; must be >= 1.

Ports:
clk  in  1  clock; all logic on the rising edge.
rstn  in  1  synchronous reset, active-low.
start  in  1  begin playback; sampled only in IDLE.
stop  in  1  abort playback; effective in any state.
loop_en  in  1  on last sample, wrap to address 0 instead of finishing; sampled live.
num_samples  in  ADDR_WIDTH  samples to play; latched on start.
mem_rd_en  out  1  memory read strobe.
mem_addr  out  ADDR_WIDTH  memory read address.
mem_rd_data  in  DATA_WIDTH  read data, valid the cycle after mem_rd_en.
smp_valid  out  1  sample offered to the network.
smp_ready  in  1  network accepts the sample.
smp_data  out  DATA_WIDTH  current sample.
bit_out  out  1  smp_data[0]; the serial line to the network.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse at normal completion.
sample_count  out  16  handshakes completed since the last start; wraps at 2^16.

Behaviour:
- Reset (rstn=0 at an edge): state IDLE. All outputs 0: mem_rd_en, mem_addr, smp_valid, smp_data, bit_out, busy, done, sample_count. Internal index and hold counter are cleared.
- Latched length is len = num_samples. If num_samples is 0 or greater than MEM_DEPTH, len = MEM_DEPTH.
- IDLE:
  - start=1 and stop=0: latch len, set idx=0, clear sample_count, go to FETCH.
  - start and stop both high: stop wins; remain in IDLE.
- FETCH (1 cycle): mem_rd_en=1 and mem_addr=idx; go to WAIT. mem_rd_en is 0 in all other states.
- WAIT (1 cycle): at the closing edge, register mem_rd_data into smp_data; go to PRESENT.
- PRESENT: smp_valid=1, smp_data stable.
  - smp_ready=0: stay, holding smp_valid and smp_data.
  - smp_ready=1: handshake. Increment sample_count. If HOLD_CYCLES=1, take the advance step directly; otherwise load the hold counter with HOLD_CYCLES-2 and go to HOLD.
- HOLD: smp_valid=0, smp_data and bit_out held. Counter decrements each cycle. When it reads 0, take the advance step.
- Advance step:
  - idx < len-1: idx+1, go to FETCH.
  - idx = len-1 and loop_en=1: idx=0, go to FETCH.
  - idx = len-1 and loop_en=0: go to DONE.
- DONE (1 cycle): done=1, then IDLE.
- Retained after completion or abort: smp_data, bit_out and sample_count keep their last values in IDLE until the next start or reset.
- Latency: start sampled at edge k gives mem_rd_en in cycle k+1 and smp_valid in cycle k+3.
- Sample period with smp_ready held high: exactly HOLD_CYCLES+2 cycles (FETCH, WAIT, then HOLD_CYCLES cycles from handshake).
- stop=1 in any non-IDLE state: next state IDLE. smp_valid drops, any in-flight read data is discarded, no done pulse. stop overrides a same-cycle handshake, but that handshake still counts in sample_count.
- start while busy: ignored.
- Reset mid-operation: identical to power-on reset; no done pulse.

Test Plan:
- Reset: rstn=0 for 2 cycles during PRESENT -> after the next edge all outputs are 0 and busy=0.
- One-shot: memory[0..3]=8'h01,8'h02,8'h03,8'h80; num_samples=4; HOLD_CYCLES=10; smp_ready=1; pulse start.
  - Handshakes occur exactly 12 cycles apart, carrying 01,02,03,80.
  - bit_out sequence is 1,0,1,0.
  - A single done pulse follows the 10-cycle hold of sample 3; sample_count=4; busy=0 afterwards.
- Backpressure: smp_ready=0 for 5 cycles at sample 1 -> smp_valid and smp_data=8'h02 held stable; stream resumes with no loss or duplication; sample_count ends at 4.
- Loop: loop_en=1, num_samples=2 -> mem_addr sequence 0,1,0,1,...; no done pulse. Then clear loop_en -> done fires after the next sample at idx 1.
- Abort: stop pulsed in WAIT of sample 2 -> IDLE next cycle, no done, sample_count=2. A start raised together with stop is ignored.
- Length bounds: num_samples=0 and num_samples=120 -> 100 handshakes, last mem_addr=99, then done.

Source files
------------

// File: rtl/sample_sequencer.sv
// Sample playback sequencer: walks a synchronous sample memory from address 0,
// offers each sample on a valid/ready stream, holds it for a fixed number of
// cycles after acceptance, and drives bit 0 of the current sample as the
// serial line. Supports one-shot and loop playback, abort and a done pulse.
module sample_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 100,
  parameter int ADDR_WIDTH  = 7,
  parameter int HOLD_CYCLES = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [ADDR_WIDTH-1:0] num_samples,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  smp_valid,
  input  logic                  smp_ready,
  output logic [DATA_WIDTH-1:0] smp_data,
  output logic                  bit_out,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           sample_count
);

  // Hold counter only ever holds HOLD_CYCLES-2 or less; the +1 keeps the
  // width at least one bit when HOLD_CYCLES is 1.
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    CNT_W'((HOLD_CYCLES >= 2) ? HOLD_CYCLES - 2 : 0);
  // One extra bit so a depth equal to 2^ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] idx, idx_nx;
  logic [ADDR_WIDTH:0]   len, len_nx;
  logic [ADDR_WIDTH:0]   len_req;
  logic [CNT_W-1:0]      hold_cnt, hold_nx;
  logic [DATA_WIDTH-1:0] data_nx;
  logic [15:0]           count_nx;
  logic                  advance;
  logic                  last;

  // Requested length, clamped to the whole memory when zero or too large.
  always_comb begin
    len_req = {1'b0, num_samples};
    if (num_samples == '0 || len_req > DEPTH) len_req = DEPTH;
  end

  assign last = ({1'b0, idx} == len - (ADDR_WIDTH + 1)'(1));

  // Next-state and datapath updates for the playback sequence.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, otherwise paths
    // that skip an assignment infer latches.
    state_nx = state;
    idx_nx   = idx;
    len_nx   = len;
    hold_nx  = hold_cnt;
    data_nx  = smp_data;
    count_nx = sample_count;
    advance  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          len_nx   = len_req;
          idx_nx   = '0;
          count_nx = '0;
          state_nx = S_FETCH;
        end
      end
      S_FETCH: state_nx = S_WAIT;
      S_WAIT: begin
        data_nx  = mem_rd_data;
        state_nx = S_PRESENT;
      end
      S_PRESENT: begin
        if (smp_ready) begin
          count_nx = sample_count + 16'd1;
          if (HOLD_CYCLES == 1) begin
            advance = 1'b1;
          end else begin
            hold_nx  = HOLD_LOAD;
            state_nx = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt == '0) advance = 1'b1;
        else                hold_nx = hold_cnt - CNT_W'(1);
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    // Move to the next sample, wrap for loop playback, or finish.
    if (advance) begin
      if (!last) begin
        idx_nx   = idx + ADDR_WIDTH'(1);
        state_nx = S_FETCH;
      end else if (loop_en) begin
        idx_nx   = '0;
        state_nx = S_FETCH;
      end else begin
        state_nx = S_DONE;
      end
    end

    // Abort wins over everything; read data still in flight is dropped, but
    // a handshake in the same cycle has already been counted above.
    if (stop && state != S_IDLE) begin
      state_nx = S_IDLE;
      data_nx  = smp_data;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rstn) begin
      state        <= S_IDLE;
      idx          <= '0;
      len          <= '0;
      hold_cnt     <= '0;
      smp_data     <= '0;
      sample_count <= '0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      len          <= len_nx;
      hold_cnt     <= hold_nx;
      smp_data     <= data_nx;
      sample_count <= count_nx;
    end
  end

  assign mem_rd_en = (state == S_FETCH);
  assign mem_addr  = idx;
  assign smp_valid = (state == S_PRESENT);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign bit_out   = smp_data[0];

endmodule

// File: tb/tb_sample_sequencer.sv
// Self-checking bench for sample_sequencer. A cycle-scheduled model predicts
// fetch, presentation, handshake and done timing from the playback rules;
// directed tests add hand-computed literal expectations.
module tb_sample_sequencer;

  localparam int DW    = 8;
  localparam int DEPTH = 100;
  localparam int AW    = 7;
  localparam int HOLD  = 10;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [AW-1:0] num_samples = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          smp_valid;
  logic          smp_ready = 1'b0;
  logic [DW-1:0] smp_data;
  logic          bit_out;
  logic          busy;
  logic          done;
  logic [15:0]   sample_count;

  sample_sequencer #(
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (DEPTH),
    .ADDR_WIDTH (AW),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .num_samples (num_samples),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .smp_valid   (smp_valid),
    .smp_ready   (smp_ready),
    .smp_data    (smp_data),
    .bit_out     (bit_out),
    .busy        (busy),
    .done        (done),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  // Synchronous sample memory: data appears the cycle after the strobe.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model state and logs ----------------
  bit  m_active = 0, m_valid = 0;
  int  m_addr = 0, m_len = 1, m_count = 0;
  int  fetch_cyc = -1, done_cyc = -1;
  bit  was_active, exp_rd, exp_done;
  logic [DW-1:0] hs_data[$];
  logic          hs_bit[$];
  int            hs_cyc[$];
  int            fetch_log[$];
  int            fetch_cyc_log[$];
  int            done_cnt = 0, done_at = -1;

  // Compare process: outputs sampled on the falling edge, then the model is
  // advanced using the inputs the DUT will see at the next rising edge.
  always @(negedge clk) begin
    if (!rstn) begin
      m_active  = 0;
      m_valid   = 0;
      m_count   = 0;
      fetch_cyc = -1;
      done_cyc  = -1;
    end else begin
      was_active = m_active;
      exp_rd     = m_active && (cyc == fetch_cyc);
      exp_done   = m_active && (cyc == done_cyc);
      if (m_active && cyc == fetch_cyc + 2) m_valid = 1;

      check("mem_rd_en", mem_rd_en, exp_rd);
      if (exp_rd) check("mem_addr", mem_addr, m_addr);
      check("smp_valid", smp_valid, m_valid);
      check("done", done, exp_done);
      check("busy", busy, m_active);
      check("sample_count", sample_count, m_count);
      if (m_valid) begin
        check("smp_data", smp_data, mem[m_addr]);
        check("bit_out", bit_out, mem[m_addr][0]);
      end

      if (mem_rd_en) begin
        fetch_log.push_back(int'(mem_addr));
        fetch_cyc_log.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end

      if (m_valid && smp_ready) begin
        m_count++;
        hs_data.push_back(smp_data);
        hs_bit.push_back(bit_out);
        hs_cyc.push_back(cyc);
        m_valid = 0;
        if (m_addr == m_len - 1 && !loop_en) begin
          done_cyc = cyc + HOLD;
        end else begin
          fetch_cyc = cyc + HOLD;
          m_addr    = (m_addr + 1) % m_len;
        end
      end

      if (exp_done) m_active = 0;
      if (was_active && stop) begin
        m_active = 0;
        m_valid  = 0;
      end else if (!was_active && start && !stop) begin
        m_active  = 1;
        fetch_cyc = cyc + 1;
        done_cyc  = -1;
        m_addr    = 0;
        m_count   = 0;
        m_len     = (num_samples == 0 || int'(num_samples) > DEPTH) ? DEPTH : int'(num_samples);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    hs_data.delete();
    hs_bit.delete();
    hs_cyc.delete();
    fetch_log.delete();
    fetch_cyc_log.delete();
    done_cnt = 0;
    done_at  = -1;
  endtask

  int start_cyc;
  task automatic pulse_start(input logic [AW-1:0] n);
    num_samples = n;
    start       = 1'b1;
    start_cyc   = cyc;
    step();
    start       = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    if (busy) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_fetch(input int a, input int budget);
    int n = 0;
    while (!(mem_rd_en && int'(mem_addr) == a) && n < budget) begin
      step();
      n++;
    end
    if (!(mem_rd_en && int'(mem_addr) == a)) check("fetch_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, mem_rd_en, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_valid"}, smp_valid, 0);
    check({tag, "_data"}, smp_data, 0);
    check({tag, "_bit"}, bit_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_count"}, sample_count, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 37 + 5);
    mem[0] = 8'h01;
    mem[1] = 8'h02;
    mem[2] = 8'h03;
    mem[3] = 8'h80;

    step();
    step();
    check_all_zero("por");
    rstn = 1'b1;
    step();

    // One-shot, four samples, ready always high.
    smp_ready = 1'b1;
    clear_logs();
    pulse_start(7'd4);
    wait_idle(200);
    check("os_hs_count", hs_data.size(), 4);
    if (hs_data.size() == 4) begin
      check("os_d0", hs_data[0], 8'h01);
      check("os_d1", hs_data[1], 8'h02);
      check("os_d2", hs_data[2], 8'h03);
      check("os_d3", hs_data[3], 8'h80);
      check("os_b0", hs_bit[0], 1);
      check("os_b1", hs_bit[1], 0);
      check("os_b2", hs_bit[2], 1);
      check("os_b3", hs_bit[3], 0);
      for (int i = 0; i < 3; i++) check("os_period", hs_cyc[i+1] - hs_cyc[i], 12);
      check("os_done_time", done_at - hs_cyc[3], 10);
    end
    // FETCH is the cycle right after the start edge; valid two cycles later.
    if (fetch_cyc_log.size() > 0) check("os_fetch_lat", fetch_cyc_log[0] - start_cyc, 1);
    if (hs_cyc.size() > 0) check("os_valid_lat", hs_cyc[0] - start_cyc, 3);
    check("os_done_cnt", done_cnt, 1);
    check("os_count", sample_count, 4);
    check("os_busy", busy, 0);
    step();
    step();
    check("os_keep_data", smp_data, 8'h80);
    check("os_keep_bit", bit_out, 0);
    check("os_keep_count", sample_count, 4);

    // Backpressure on sample 1 for five cycles.
    clear_logs();
    pulse_start(7'd4);
    wait_fetch(1, 50);
    smp_ready = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", smp_valid, 1);
      check("bp_data", smp_data, 8'h02);
      step();
    end
    smp_ready = 1'b1;
    wait_idle(200);
    check("bp_hs_count", hs_data.size(), 4);
    if (hs_data.size() == 4) begin
      check("bp_d1", hs_data[1], 8'h02);
      check("bp_d2", hs_data[2], 8'h03);
      check("bp_gap", hs_cyc[1] - hs_cyc[0], 17);
    end
    check("bp_count", sample_count, 4);
    check("bp_done_cnt", done_cnt, 1);

    // Loop playback over two samples, then release loop_en.
    clear_logs();
    loop_en = 1'b1;
    pulse_start(7'd2);
    begin
      int n = 0;
      while (fetch_log.size() < 5 && n < 200) begin
        step();
        n++;
      end
    end
    check("lp_fetches", fetch_log.size(), 5);
    if (fetch_log.size() >= 5) begin
      check("lp_a0", fetch_log[0], 0);
      check("lp_a1", fetch_log[1], 1);
      check("lp_a2", fetch_log[2], 0);
      check("lp_a3", fetch_log[3], 1);
      check("lp_a4", fetch_log[4], 0);
    end
    check("lp_no_done", done_cnt, 0);
    loop_en = 1'b0;
    wait_idle(200);
    check("lp_done_cnt", done_cnt, 1);
    check("lp_fetch_total", fetch_log.size(), 6);
    if (fetch_log.size() == 6) check("lp_last_addr", fetch_log[5], 1);
    check("lp_count", sample_count, 6);

    // Abort during WAIT of sample 2, with start raised alongside stop.
    clear_logs();
    pulse_start(7'd4);
    wait_fetch(2, 50);
    step();
    stop  = 1'b1;
    start = 1'b1;
    step();
    stop  = 1'b0;
    start = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_valid", smp_valid, 0);
    check("ab_count", sample_count, 2);
    check("ab_keep_data", smp_data, 8'h02);
    step();
    step();
    check("ab_still_idle", busy, 0);
    check("ab_no_done", done_cnt, 0);

    // start and stop together in IDLE: stays idle.
    stop  = 1'b1;
    start = 1'b1;
    step();
    stop  = 1'b0;
    start = 1'b0;
    step();
    check("ss_idle", busy, 0);
    check("ss_count", sample_count, 2);

    // Length bounds: zero and over-depth both play the whole memory.
    clear_logs();
    pulse_start(7'd0);
    wait_idle(2000);
    check("len0_hs", hs_data.size(), 100);
    if (fetch_log.size() > 0) check("len0_last", fetch_log[fetch_log.size()-1], 99);
    check("len0_done", done_cnt, 1);
    check("len0_count", sample_count, 100);

    clear_logs();
    pulse_start(7'd120);
    wait_idle(2000);
    check("len120_hs", hs_data.size(), 100);
    if (fetch_log.size() > 0) check("len120_last", fetch_log[fetch_log.size()-1], 99);
    check("len120_done", done_cnt, 1);
    check("len120_count", sample_count, 100);

    // Reset for two cycles while a sample is being presented.
    smp_ready = 1'b0;
    pulse_start(7'd4);
    begin
      int n = 0;
      while (!smp_valid && n < 20) begin
        step();
        n++;
      end
    end
    check("rs_presenting", smp_valid, 1);
    check("rs_pre_data", smp_data, 8'h01);
    rstn = 1'b0;
    step();
    check_all_zero("rs1");
    step();
    check_all_zero("rs2");
    rstn = 1'b1;
    smp_ready = 1'b1;
    step();
    step();
    check("rs_after_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
